// File: rtl/ppu_oam.sv
// rtl/ppu_oam.sv - sprite OAM responder for $2003/$2004 with renderer read port
// 256x8 object attribute memory with auto-incrementing bus address.
module ppu_oam (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_tick,
  input  logic [15:0] I_addr,
  input  logic        I_rdwr,
  input  logic [7:0]  I_data,
  output logic [7:0]  O_data,
  output logic        O_hit,
  input  logic        I_render,
  input  logic [7:0]  I_raddr,
  output logic [7:0]  O_rdata
);

  logic [7:0] mem [0:255];
  logic [7:0] oam_addr;
  logic       sel;
  logic [2:0] reg_sel;
  logic       bus_ev;
  logic       wr_addr;
  logic       wr_data;
  logic       unused_addr_bits;

  // Attribute bytes (index % 4 == 2) have no storage behind bits 4:2 on real hardware.
  function automatic logic [7:0] attr_mask(input logic [7:0] d, input logic [7:0] a);
    return (a[1:0] == 2'b10) ? (d & 8'hE3) : d;
  endfunction

  assign sel              = (I_addr[15:13] == 3'b001);
  assign reg_sel          = I_addr[2:0];
  assign bus_ev           = I_tick && sel && !I_reset;
  assign wr_addr          = bus_ev && !I_rdwr && (reg_sel == 3'd3);
  assign wr_data          = bus_ev && !I_rdwr && (reg_sel == 3'd4);
  assign unused_addr_bits = ^I_addr[12:3];

  always_comb begin
    O_hit  = 1'b0;
    O_data = 8'h00;
    if (bus_ev && I_rdwr && (reg_sel == 3'd4)) begin
      O_hit  = 1'b1;
      O_data = attr_mask(mem[oam_addr], oam_addr);
    end
  end

  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      oam_addr <= 8'h00;
    end else if (wr_addr) begin
      oam_addr <= I_data;
    end else if (wr_data) begin
      oam_addr <= oam_addr + 8'd1;
    end
  end

  // Memory has no reset; contents survive I_reset.
  always_ff @(posedge I_clock) begin
    if (wr_data && !I_render) begin
      mem[oam_addr] <= I_data;
    end
  end

  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      O_rdata <= 8'h00;
    end else begin
      O_rdata <= attr_mask(mem[I_raddr], I_raddr);
    end
  end

endmodule

// File: doc/ppu_oam.md
# ppu_oam

Sprite object attribute memory (OAM) responder for the PPU side of the 2A03 bus. It decodes CPU/DMA bus cycles to OAMADDR ($2003) and OAMDATA ($2004), stores bytes into a 256×8 OAM with auto-incrementing address, and serves reads back to the bus. It also provides a separate registered read port for the sprite renderer. It is the receiving end of the 256-byte OAM DMA burst issued by the core DMA engine, which writes $2004 repeatedly.

## Interface

Parameters:
- none

Ports:
- I_clock  input  1  system clock; all state changes on rising edge
- I_reset  input  1  synchronous, active-high reset
- I_tick  input  1  CPU bus cycle strobe; bus inputs are sampled only when high
- I_addr  input  16  bus address
- I_rdwr  input  1  bus direction: 1 = read, 0 = write
- I_data  input  8  bus write data
- O_data  output  8  bus read data, valid while O_hit is high
- O_hit  output  1  combinational; high when the current bus cycle is a read of $2004 that this block drives
- I_render  input  1  renderer owns OAM; CPU/DMA data writes are suppressed
- I_raddr  input  8  renderer read address
- O_rdata  output  8  renderer read data, registered

## Operation

Address decode:
- PPU register space is $2000–$3FFF, mirrored every 8 bytes.
- sel = (I_addr[15:13] == 3'b001).
- reg = I_addr[2:0].

Internal state:
- oam_addr[7:0]
- mem[0:255][7:0]
- O_rdata register

State updates:
- An event happens only on a clock edge with I_tick = 1, sel = 1 and no reset.
- Write to reg 3 (OAMADDR): oam_addr ← I_data.
- Write to reg 4 (OAMDATA):
  - If I_render = 0: mem[oam_addr] ← I_data.
  - Independent of I_render: oam_addr ← oam_addr + 1, modulo 256 (255 → 0).
- Read of reg 4:
  - O_hit = 1.
  - O_data = mem[oam_addr], masked.
  - oam_addr is unchanged.
- Read of reg 3: write-only register. O_hit = 0 (open bus, not driven by this block).
- Any other reg, direction, or sel = 0:
  - No state change.
  - O_hit = 0.
  - O_data = 8'h00.

Read masking:
- Applies when oam_addr[1:0] == 2'b10 (attribute byte).
- Bits 4:2 read as 0: O_data = mem & 8'hE3.
- The stored value keeps all 8 bits. The renderer port applies the same mask.

Renderer port:
- Every clock: O_rdata ← masked mem[I_raddr].
- Active regardless of I_tick and I_render.

DMA burst:
- A burst is 256 consecutive $2004 writes starting at any oam_addr N.
- It fills all 256 entries; entry (N+k) mod 256 receives byte k.
- oam_addr ends back at N.

## Timing

- O_hit and O_data are combinational from I_addr, I_rdwr, I_tick and current state, so data is available within the same tick cycle.
- O_rdata has 1-cycle latency from I_raddr.
- Write effects are visible on the clock following the edge.
- Write followed by read:
  - A $2004 write on tick T increments oam_addr.
  - A $2004 read on tick T+1 returns the entry after the one written.
- Same-cycle collision, CPU write and renderer read at the same address: O_rdata returns the old data (read-before-write).
- Reset (synchronous, any cycle, including mid-DMA):
  - oam_addr ← 0.
  - O_rdata ← 0.
  - O_hit = 0 and O_data = 0 while I_reset is high.
  - A write coinciding with reset is discarded.
  - mem contents are not cleared, and the bench must not depend on them.
- I_tick low: bus inputs are ignored entirely; only the renderer port updates.

## Test plan

- Reset, write $2003 = 8'h10, then write $2004 with 8'hAA, 8'hBB → mem[16] = AA, mem[17] = BB, oam_addr = 8'h12.
- Write $2003 = 8'hFF, then DMA of 256 bytes k = 0..255 → mem[(255+k) mod 256] = k, oam_addr = 8'hFF, and reads of $2004 around the 255→0 boundary return the expected bytes (masked at index%4 == 2).
- Write 8'hFF at index 2, read $2004 at oam_addr 2 → O_hit = 1, O_data = 8'hE3; O_rdata with I_raddr = 2 → 8'hE3 one cycle later; a read of $2003 gives O_hit = 0.
- Mirror decode: write $3FFB = 8'h40 (reg 3) → oam_addr = 8'h40; write $4004 → no effect, O_hit = 0.
- I_render = 1, $2004 write of 8'h55 at oam_addr 8'h20 whose old contents are 8'h11 → mem[32] stays 8'h11, oam_addr = 8'h21; same-cycle renderer read of address 32 during a CPU write returns the old value.
- Assert I_reset at DMA byte 100 → oam_addr = 0 the next cycle, O_rdata = 0, the coincident write is discarded, and subsequent writes start at index 0.
